mm_bram_parallel_ctrl: RTL
==========================

Name: mm_bram_parallel_ctrl

Overview:
Controller stage directly upstream of the parallel BRAM matrix-multiply datapath. On `start` it sweeps the source SRAM row by row. It delays the issue strobe and row index by the SRAM read latency, so `dpath_sum_en` and `dpath_result_wraddr` arrive aligned with `row_data_in`. It then counts result-row write strobes coming back from the datapath and signals completion once every row has been written.

Parameters:
- ROW_NUM, 32, rows in the source matrix (≥2).
- COL_NUM, 32, datapath column lanes (width of the returned `row_wr_en`).
- SRAM_RD_LATENCY, 1, source SRAM read latency in cycles (≥1).
- ROW_ADDR_WIDTH, $clog2(ROW_NUM), derived, not set manually.
- CNT_WIDTH, $clog2(ROW_NUM+1), derived, not set manually.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, one-cycle request to begin a full pass; sampled only in IDLE.
- stall, input, 1, while high, no new source read is issued.
- src_rd_en, output, 1, source SRAM read enable.
- src_rdaddr, output, ROW_ADDR_WIDTH, source SRAM row address.
- dpath_sum_en, output, 1, to datapath: `row_data_in` is valid this cycle.
- dpath_result_wraddr, output, ROW_ADDR_WIDTH, to datapath: destination row of the current data.
- row_wr_en, input, COL_NUM, write strobes returned from the datapath lanes.
- busy, output, 1, high from the cycle after `start` is accepted until `done`.
- done, output, 1, one-cycle pulse when the last row write has been observed.
- lane_err, output, 1, sticky; set when `row_wr_en` is neither all-zero nor all-one.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; delay line cleared.
- Reset mid-operation: the next cycle is IDLE with everything cleared. In-flight datapath results arriving afterwards are ignored, and `lane_err` is not set by them in IDLE.
- States:
  - IDLE: `start` → ISSUE, `issue_cnt` cleared to 0, `ret_cnt` cleared to 0. `start` in any other state is ignored.
  - ISSUE: each cycle with `stall`=0: `src_rd_en`=1, `src_rdaddr`=`issue_cnt`, `issue_cnt`++. With `stall`=1: `src_rd_en`=0 and the address holds. After address ROW_NUM-1 is issued → DRAIN in the next cycle.
  - DRAIN: no reads issued; wait for `ret_cnt` to reach ROW_NUM.
  - DONE: `done`=1 for exactly one cycle, `busy`=0 → IDLE.
- `src_rd_en` and `src_rdaddr` are combinational from state, `issue_cnt` and `stall`. This makes the SRAM read cycle the issue cycle.
- Alignment delay line: a shift register of depth SRAM_RD_LATENCY carrying {`src_rd_en`, `src_rdaddr`}.
  - `dpath_sum_en` and `dpath_result_wraddr` are its registered output: the issue in cycle t appears in cycle t+SRAM_RD_LATENCY.
  - It advances every cycle regardless of `stall`, because the datapath pipeline cannot stall.
- Return counting: `ret_cnt` (CNT_WIDTH bits) increments when `row_wr_en[0]`=1 while `busy`.
  - The `ret_cnt`=ROW_NUM check is made in the cycle after the increment, giving DRAIN → DONE.
  - If the last return arrives while still in ISSUE (not possible for a real datapath), the check still fires once the state reaches DRAIN.
- `lane_err`: set in any `busy` cycle where `row_wr_en` is neither all-zero nor all-one. Cleared only by reset or by a newly accepted `start`.
- Counter widths:
  - `issue_cnt` is CNT_WIDTH bits.
  - `src_rdaddr` is its low ROW_ADDR_WIDTH bits.
  - There is no wrap within a pass.
- Simultaneous events:
  - `stall` during the final address: that address is delayed, not dropped.
  - A return strobe in the same cycle as the last issue is counted normally.

Decomposition:
- Shared package `mm_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mm_ctrl_state_t`.
  - Helper localparams for derived widths.
- One sub-module is natural: `valid_addr_delay`, parameterised (WIDTH, DEPTH), a synchronous-reset shift pipeline. It is reusable for aligning other SRAM-fed stages.

Test Plan:
Bench uses ROW_NUM=4, COL_NUM=4, SRAM_RD_LATENCY=2. The bench models the datapath as a 3-cycle delay of `dpath_sum_en` fanned out to all four `row_wr_en` bits.
- Basic pass: `start` at cycle 0 → `src_rdaddr` 0,1,2,3 in cycles 1–4. `dpath_sum_en` high in cycles 3–6 with `dpath_result_wraddr` 0,1,2,3. Returns in cycles 6–9. `done` pulses in cycle 10 and `busy` drops with it.
- Stall: `stall`=1 in cycles 2–3 of the same pass → addresses 0,(hold),(hold),1,2,3. `dpath_sum_en` has the matching 2-cycle gap. Exactly 4 returns are counted and `done` arrives 2 cycles later than the basic pass.
- Start while busy: a second `start` pulse at cycle 3 → ignored. Only 4 reads are issued and there is a single `done`.
- Reset mid-DRAIN: `reset` at cycle 7 → the next cycle has all outputs 0. Remaining returns produce no `done` and no `lane_err`. A fresh `start` then completes a normal pass.
- Lane mismatch: the model forces `row_wr_en`=4'b0111 on the second return → `lane_err`=1 and it stays 1 through `done`. It is cleared on the next accepted `start`.
- Back-to-back: `start` in the cycle after `done` → the second pass has timing identical to the basic pass, shifted accordingly.

Source files
------------

// File: rtl/mm_bram_parallel_ctrl_pkg.sv
// Shared types and width helpers for the BRAM matrix-multiply controller.
package mm_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mm_ctrl_state_t;

   // Default geometry of the datapath this controller feeds
   localparam int DEF_ROW_NUM         = 32;
   localparam int DEF_COL_NUM         = 32;
   localparam int DEF_SRAM_RD_LATENCY = 1;

   // Row address width; never narrower than one bit
   function automatic int row_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold the value n itself (terminal count)
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mm_bram_parallel_ctrl_if.sv
// Handshake/bus bundle between the controller, its host, the source SRAM
// and the datapath. slave = controller view, master = environment view.
interface mm_bram_parallel_ctrl_if
   import mm_ctrl_pkg::*;
#(
   parameter int ROW_NUM = DEF_ROW_NUM,
   parameter int COL_NUM = DEF_COL_NUM
);
   localparam int ROW_ADDR_WIDTH = row_addr_w(ROW_NUM);

   logic                      start;
   logic                      stall;
   logic                      src_rd_en;
   logic [ROW_ADDR_WIDTH-1:0] src_rdaddr;
   logic                      dpath_sum_en;
   logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr;
   logic [COL_NUM-1:0]        row_wr_en;
   logic                      busy;
   logic                      done;
   logic                      lane_err;

   modport slave (
      input  start, stall, row_wr_en,
      output src_rd_en, src_rdaddr, dpath_sum_en, dpath_result_wraddr,
             busy, done, lane_err
   );

   modport master (
      output start, stall, row_wr_en,
      input  src_rd_en, src_rdaddr, dpath_sum_en, dpath_result_wraddr,
             busy, done, lane_err
   );

endinterface

// File: rtl/mm_bram_parallel_ctrl_valid_addr_delay.sv
// Fixed-depth shift pipeline used to line a read strobe/address up with the
// data coming back from a synchronous SRAM. Never stalls.
module valid_addr_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   // Shift one stage per cycle; reset flushes every stage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/mm_bram_parallel_ctrl.sv
// Row-sweep controller in front of the parallel BRAM matrix-multiply
// datapath: issues source reads, aligns the issue strobe with SRAM data,
// counts returned row writes and pulses done when the pass is complete.
module mm_bram_parallel_ctrl
   import mm_ctrl_pkg::*;
#(
   parameter int ROW_NUM         = DEF_ROW_NUM,
   parameter int COL_NUM         = DEF_COL_NUM,
   parameter int SRAM_RD_LATENCY = DEF_SRAM_RD_LATENCY
) (
   input  logic                   clk,
   input  logic                   reset,
   mm_bram_parallel_ctrl_if.slave bus
);

   localparam int ROW_ADDR_WIDTH = row_addr_w(ROW_NUM);
   localparam int CNT_WIDTH      = cnt_w(ROW_NUM);
   localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(ROW_NUM - 1);
   localparam logic [CNT_WIDTH-1:0] ALL_ROWS = CNT_WIDTH'(ROW_NUM);

   mm_ctrl_state_t r_state;
   mm_ctrl_state_t w_state_nxt;

   logic [CNT_WIDTH-1:0]      r_issue_cnt;
   logic [CNT_WIDTH-1:0]      r_ret_cnt;
   logic [CNT_WIDTH-1:0]      w_ret_cnt_nxt;
   logic                      r_lane_err;
   logic                      w_busy;
   logic                      w_accept;
   logic                      w_issue;
   logic                      w_ret;
   logic                      w_lane_bad;
   logic [ROW_ADDR_WIDTH-1:0] w_rdaddr;
   logic [ROW_ADDR_WIDTH:0]   w_align_q;

   assign w_busy     = (r_state == ISSUE) || (r_state == DRAIN);
   assign w_accept   = (r_state == IDLE) && bus.start;
   assign w_issue    = (r_state == ISSUE) && !bus.stall;
   assign w_ret      = w_busy && bus.row_wr_en[0];
   assign w_lane_bad = (bus.row_wr_en != '0) && (bus.row_wr_en != '1);
   assign w_rdaddr   = r_issue_cnt[ROW_ADDR_WIDTH-1:0];

   // Return count including this cycle's strobe. Looking at it in DRAIN lets
   // done land in the cycle right after the last return; a terminal count
   // already reached during ISSUE also satisfies it once DRAIN is entered.
   assign w_ret_cnt_nxt = r_ret_cnt + CNT_WIDTH'(w_ret);

   // Next-state logic for the pass sequencer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = ISSUE;
         ISSUE:   if (w_issue && (r_issue_cnt == LAST_ROW)) w_state_nxt = DRAIN;
         DRAIN:   if (w_ret_cnt_nxt == ALL_ROWS) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, counters and sticky lane error
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
         r_lane_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_lane_err  <= 1'b0;
         end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_WIDTH'(1);
            r_ret_cnt <= w_ret_cnt_nxt;
            if (w_busy && w_lane_bad) r_lane_err <= 1'b1;
         end
      end
   end

   // Read strobe/address delayed by the SRAM latency so the datapath sees
   // them together with the row data
   valid_addr_delay #(
      .WIDTH (ROW_ADDR_WIDTH + 1),
      .DEPTH (SRAM_RD_LATENCY)
   ) u_align (
      .clk   (clk),
      .reset (reset),
      .i_d   ({w_issue, w_rdaddr}),
      .o_q   (w_align_q)
   );

   assign bus.src_rd_en           = w_issue;
   assign bus.src_rdaddr          = w_rdaddr;
   assign bus.dpath_sum_en        = w_align_q[ROW_ADDR_WIDTH];
   assign bus.dpath_result_wraddr = w_align_q[ROW_ADDR_WIDTH-1:0];
   assign bus.busy                = w_busy;
   assign bus.done                = (r_state == DONE);
   assign bus.lane_err            = r_lane_err;

endmodule
